// File: rtl/pong_serve_controller.sv
// pong_serve_controller: Pong round sequencer (serve countdown, scoring, game over)
module pong_serve_controller #(
    parameter int SERVE_DELAY_SECONDS = 3,
    parameter int COUNT_WIDTH = 3,
    parameter int WIN_SCORE = 9,
    parameter int SCORE_WIDTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Restart,
    input  logic                   PointLeft,
    input  logic                   PointRight,
    input  logic                   TimerTimeout,
    output logic                   TimerStart,
    output logic                   ServeEnable,
    output logic                   ServeDirection,
    output logic [COUNT_WIDTH-1:0] CountdownValue,
    output logic [SCORE_WIDTH-1:0] ScoreLeft,
    output logic [SCORE_WIDTH-1:0] ScoreRight,
    output logic                   GameOver
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT, PLAY, DRAIN, OVER} state_t;
    localparam logic [COUNT_WIDTH-1:0] RELOAD = COUNT_WIDTH'(SERVE_DELAY_SECONDS);
    localparam logic [SCORE_WIDTH-1:0] WIN = SCORE_WIDTH'(WIN_SCORE);
    state_t state;
    logic [SCORE_WIDTH-1:0] left_inc, right_inc;
    logic let_point, win_point, hold_drain;
    assign left_inc = ScoreLeft + SCORE_WIDTH'(1);
    assign right_inc = ScoreRight + SCORE_WIDTH'(1);
    assign let_point = PointLeft && PointRight;
    assign win_point = !let_point && (PointLeft ? left_inc == WIN : right_inc == WIN);
    // a restart while the timer is still counting must swallow its pending timeout first
    assign hold_drain = state == WAIT && !TimerTimeout;
    // round sequencer with all outputs registered; restart overrides everything except an active drain
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            TimerStart <= 1'b0;
            ServeEnable <= 1'b0;
            ServeDirection <= 1'b0;
            CountdownValue <= '0;
            ScoreLeft <= '0;
            ScoreRight <= '0;
            GameOver <= 1'b0;
        end else begin
            TimerStart <= 1'b0;
            if (Restart && state != DRAIN) begin
                state <= hold_drain ? DRAIN : ARM;
                TimerStart <= !hold_drain;
                ServeEnable <= 1'b0;
                ServeDirection <= 1'b0;
                CountdownValue <= RELOAD;
                ScoreLeft <= '0;
                ScoreRight <= '0;
                GameOver <= 1'b0;
            end else begin
                case (state)
                    ARM: state <= WAIT;
                    WAIT: if (TimerTimeout) begin
                        CountdownValue <= CountdownValue - COUNT_WIDTH'(1);
                        if (CountdownValue == COUNT_WIDTH'(1)) begin
                            state <= PLAY;
                            ServeEnable <= 1'b1;
                        end else begin
                            state <= ARM;
                            TimerStart <= 1'b1;
                        end
                    end
                    DRAIN: if (TimerTimeout) begin
                        state <= ARM;
                        TimerStart <= 1'b1;
                    end
                    PLAY: if (PointLeft || PointRight) begin
                        ServeEnable <= 1'b0;
                        if (PointLeft && !PointRight) begin
                            ScoreLeft <= left_inc;
                            ServeDirection <= 1'b1;
                        end
                        if (PointRight && !PointLeft) begin
                            ScoreRight <= right_inc;
                            ServeDirection <= 1'b0;
                        end
                        state <= win_point ? OVER : ARM;
                        TimerStart <= !win_point;
                        GameOver <= win_point;
                        CountdownValue <= win_point ? '0 : RELOAD;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pong_serve_controller.sv
// tb_pong_serve_controller: directed bench with a one-second timer model (terminal count 3)
module tb_pong_serve_controller;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic Restart = 1'b0, PointLeft = 1'b0, PointRight = 1'b0, TimerTimeout;
    logic TimerStart, ServeEnable, ServeDirection, GameOver;
    logic [2:0] CountdownValue;
    logic [3:0] ScoreLeft, ScoreRight;
    logic [2:0] tcnt;
    logic trun;
    int checks = 0, failures = 0;
    int n_st, play_cyc;
    int st_cyc[8];
    logic [2:0] st_cd[8];

    pong_serve_controller dut (
        .Clock(Clock), .Reset(Reset), .Restart(Restart), .PointLeft(PointLeft),
        .PointRight(PointRight), .TimerTimeout(TimerTimeout), .TimerStart(TimerStart),
        .ServeEnable(ServeEnable), .ServeDirection(ServeDirection),
        .CountdownValue(CountdownValue), .ScoreLeft(ScoreLeft), .ScoreRight(ScoreRight),
        .GameOver(GameOver)
    );

    always #5 Clock = ~Clock;

    // one-second timer stand-in: Start loads 3, Timeout pulses after counting down past 0
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tcnt <= '0;
            trun <= 1'b0;
            TimerTimeout <= 1'b0;
        end else begin
            TimerTimeout <= 1'b0;
            if (TimerStart) begin
                tcnt <= 3'd3;
                trun <= 1'b1;
            end else if (trun) begin
                if (tcnt == 3'd0) begin
                    TimerTimeout <= 1'b1;
                    trun <= 1'b0;
                end else tcnt <= tcnt - 3'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic rs, input logic pl, input logic pr);
        Restart = rs; PointLeft = pl; PointRight = pr;
        @(negedge Clock);
        Restart = 1'b0; PointLeft = 1'b0; PointRight = 1'b0;
    endtask

    task automatic run_to_play();
        n_st = 0;
        play_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            if (TimerStart) begin
                if (n_st < 8) begin
                    st_cyc[n_st] = c;
                    st_cd[n_st] = CountdownValue;
                end
                n_st++;
            end
            if (ServeEnable) begin
                play_cyc = c;
                break;
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver});
        end
        @(negedge Clock);
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        @(negedge Clock);
        checks++;
        if ({TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver} !== 15'h0) begin
            failures++;
            $display("FAIL idle_ignores_points: got %h expected 0", {TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver});
        end
    endtask

    task automatic test_countdown();
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if ({TimerStart, CountdownValue, ServeEnable, ServeDirection} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL restart_arm: got %h expected %h", {TimerStart, CountdownValue, ServeEnable, ServeDirection}, {1'b1, 3'd3, 1'b0, 1'b0});
        end
        run_to_play();
        checks++;
        if (n_st !== 3 || play_cyc !== 18) begin
            failures++;
            $display("FAIL countdown_pulses: got starts=%0d play=%0d expected starts=3 play=18", n_st, play_cyc);
        end
        checks++;
        if ({st_cd[0], st_cd[1], st_cd[2], CountdownValue} !== {3'd3, 3'd2, 3'd1, 3'd0}) begin
            failures++;
            $display("FAIL countdown_values: got %h expected %h", {st_cd[0], st_cd[1], st_cd[2], CountdownValue}, {3'd3, 3'd2, 3'd1, 3'd0});
        end
        checks++;
        if (st_cyc[1] - st_cyc[0] !== 6 || st_cyc[2] - st_cyc[1] !== 6) begin
            failures++;
            $display("FAIL countdown_spacing: got %0d,%0d expected 6,6", st_cyc[1] - st_cyc[0], st_cyc[2] - st_cyc[1]);
        end
    endtask

    task automatic test_point();
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue} !== {4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL point_left: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue}, {4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 3'd3});
        end
        run_to_play();
        checks++;
        if (n_st !== 3 || play_cyc !== 18) begin
            failures++;
            $display("FAIL point_left_countdown: got starts=%0d play=%0d expected starts=3 play=18", n_st, play_cyc);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue} !== {4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL point_right: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue}, {4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 3'd3});
        end
        run_to_play();
        checks++;
        if (play_cyc !== 18) begin
            failures++;
            $display("FAIL point_right_countdown: got play=%0d expected 18", play_cyc);
        end
    endtask

    task automatic test_let();
        drive(1'b0, 1'b1, 1'b0);
        run_to_play();
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue} !== {4'd2, 4'd1, 1'b1, 1'b0, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL let: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue}, {4'd2, 4'd1, 1'b1, 1'b0, 1'b1, 3'd3});
        end
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, TimerStart} !== {4'd2, 4'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL point_in_arm_ignored: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, TimerStart}, {4'd2, 4'd1, 1'b1, 1'b0});
        end
        run_to_play();
        checks++;
        if (n_st !== 2 || play_cyc !== 17 || {st_cd[0], st_cd[1]} !== {3'd2, 3'd1}) begin
            failures++;
            $display("FAIL let_countdown: got starts=%0d play=%0d cd=%h expected starts=2 play=17 cd=11", n_st, play_cyc, {st_cd[0], st_cd[1]});
        end
    endtask

    task automatic test_game_end();
        int ts_seen;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (i < 7) begin
                run_to_play();
                checks++;
                if (play_cyc !== 18 || ScoreRight !== 4'(i + 2)) begin
                    failures++;
                    $display("FAIL round_%0d: got play=%0d right=%0d expected play=18 right=%0d", i, play_cyc, ScoreRight, i + 2);
                end
            end
        end
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue, GameOver} !== {4'd2, 4'd9, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL game_over: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue, GameOver}, {4'd2, 4'd9, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
        end
        drive(1'b0, 1'b1, 1'b0);
        ts_seen = 0;
        for (int c = 0; c < 30; c++) begin
            ts_seen += int'(TimerStart);
            @(negedge Clock);
        end
        checks++;
        if (ts_seen !== 0 || {ScoreLeft, ScoreRight, GameOver, ServeEnable} !== {4'd2, 4'd9, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL over_frozen: got starts=%0d state=%h expected starts=0 state=%h", ts_seen, {ScoreLeft, ScoreRight, GameOver, ServeEnable}, {4'd2, 4'd9, 1'b1, 1'b0});
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ScoreLeft, ScoreRight, GameOver, TimerStart, CountdownValue, ServeDirection} !== {4'd0, 4'd0, 1'b0, 1'b1, 3'd3, 1'b0}) begin
            failures++;
            $display("FAIL over_restart: got %h expected %h", {ScoreLeft, ScoreRight, GameOver, TimerStart, CountdownValue, ServeDirection}, {4'd0, 4'd0, 1'b0, 1'b1, 3'd3, 1'b0});
        end
        run_to_play();
        checks++;
        if (n_st !== 3 || play_cyc !== 18) begin
            failures++;
            $display("FAIL over_restart_countdown: got starts=%0d play=%0d expected starts=3 play=18", n_st, play_cyc);
        end
    endtask

    task automatic test_restart_wait();
        drive(1'b0, 1'b1, 1'b0);
        repeat (7) @(negedge Clock);
        checks++;
        if ({TimerStart, CountdownValue, ServeEnable} !== {1'b0, 3'd2, 1'b0}) begin
            failures++;
            $display("FAIL wait_second_two: got %h expected %h", {TimerStart, CountdownValue, ServeEnable}, {1'b0, 3'd2, 1'b0});
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, TimerStart, CountdownValue} !== {4'd0, 4'd0, 1'b0, 1'b0, 3'd3}) begin
            failures++;
            $display("FAIL restart_in_wait: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, TimerStart, CountdownValue}, {4'd0, 4'd0, 1'b0, 1'b0, 3'd3});
        end
        run_to_play();
        checks++;
        if (n_st !== 3 || st_cyc[0] !== 4 || play_cyc !== 22) begin
            failures++;
            $display("FAIL drain_timing: got starts=%0d first=%0d play=%0d expected starts=3 first=4 play=22", n_st, st_cyc[0], play_cyc);
        end
        checks++;
        if ({st_cd[0], st_cd[1], st_cd[2]} !== {3'd3, 3'd2, 3'd1}) begin
            failures++;
            $display("FAIL drain_countdown: got %h expected %h", {st_cd[0], st_cd[1], st_cd[2]}, {3'd3, 3'd2, 3'd1});
        end
    endtask

    task automatic test_reset_play();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            run_to_play();
        end
        checks++;
        if ({ScoreLeft, ServeEnable, play_cyc} !== {4'd5, 1'b1, 32'sd18}) begin
            failures++;
            $display("FAIL five_left: got left=%0d serve=%0d play=%0d expected 5 1 18", ScoreLeft, ServeEnable, play_cyc);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver} !== 15'h0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0", {TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver});
        end
        @(negedge Clock);
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if ({TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver} !== 15'h0) begin
            failures++;
            $display("FAIL points_after_reset: got %h expected 0", {TimerStart, ServeEnable, ServeDirection, CountdownValue, ScoreLeft, ScoreRight, GameOver});
        end
        drive(1'b1, 1'b0, 1'b0);
        run_to_play();
        checks++;
        if (n_st !== 3 || play_cyc !== 18 || ScoreLeft !== 4'd0) begin
            failures++;
            $display("FAIL restart_after_reset: got starts=%0d play=%0d left=%0d expected 3 18 0", n_st, play_cyc, ScoreLeft);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0);
        run_to_play();
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if ({ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL restart_beats_point: got %h expected %h", {ScoreLeft, ScoreRight, ServeDirection, ServeEnable, TimerStart, CountdownValue}, {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd3});
        end
        run_to_play();
        checks++;
        if (n_st !== 3 || play_cyc !== 18) begin
            failures++;
            $display("FAIL restart_beats_point_countdown: got starts=%0d play=%0d expected 3 18", n_st, play_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_point();
        test_let();
        test_game_end();
        test_restart_wait();
        test_reset_play();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
